// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding, default widths and parameter helpers for csa_resolver.
package csa_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int M_DEF     = 8;
   localparam int CHUNK_DEF = 4;

   function automatic int csa_nch(input int m, input int chunk);
      return m / chunk;
   endfunction

   function automatic bit csa_legal(input int m, input int chunk);
      return chunk > 0 && m >= chunk && m % chunk == 0;
   endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// csa_chunk_add: combinational W-bit adder with carry in/out, one chunk of the resolver.
module csa_chunk_add #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save (sum, carry) pair to binary, CHUNK bits per clock.
// Optional CSA_RES_ZERO_SKIP_EN: a pair with zero carry bypasses the RUN phase.
module csa_resolver
   import csa_pkg::*;
#(
   parameter int M     = M_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] in_sum,
   input  logic [M-1:0] in_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out_soma,
   output logic [1:0]   out_carry,
   output logic         busy
);

   localparam int NCH = csa_nch(M, CHUNK);
   localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;

   if (!csa_legal(M, CHUNK)) begin : g_bad_params
      $error("csa_resolver: M must be a positive multiple of CHUNK");
   end

   state_t           state;
   logic [M-1:0]     s_reg;
   logic [M:0]       c_reg;
   logic [IW-1:0]    idx;
   logic             cy;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] r_chunk;
   logic             cy_next;

   // c_reg already holds the carry vector at weight 2, so its chunks line up with s_reg
   assign a_chunk = s_reg[idx*CHUNK +: CHUNK];
   assign b_chunk = c_reg[idx*CHUNK +: CHUNK];

   csa_chunk_add #(.W(CHUNK)) u_add (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (cy),
      .sum  (r_chunk),
      .cout (cy_next)
   );

   assign in_ready  = state == IDLE && !rst;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         s_reg     <= '0;
         c_reg     <= '0;
         idx       <= '0;
         cy        <= 1'b0;
         out_soma  <= '0;
         out_carry <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               s_reg <= in_sum;
               c_reg <= {in_cout, 1'b0};
               idx   <= '0;
               cy    <= 1'b0;
`ifdef CSA_RES_ZERO_SKIP_EN
               if (in_cout == '0) begin
                  out_soma  <= in_sum;
                  out_carry <= '0;
                  state     <= DONE;
               end else begin
                  state <= RUN;
               end
`else
               state <= RUN;
`endif
            end
            RUN: begin
               out_soma[idx*CHUNK +: CHUNK] <= r_chunk;
               cy  <= cy_next;
               idx <= idx + IW'(1);
               // top carry bit plus final chunk carry can reach 2
               if (idx == IW'(NCH-1)) begin
                  out_carry <= {1'b0, c_reg[M]} + {1'b0, cy_next};
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Sequential consumer of the redundant (sum, carry) pair produced by the carry-save 3:2 stage.
- Resolves the pair to plain binary, result = in_sum + 2*in_cout, using a CHUNK-bit carry-propagate adder over M/CHUNK cycles.
- Sits between the CSA compression tree and any binary-domain consumer.
- Replaces the single-cycle wide final adder when timing is tight.

Parameters:
- M, 8, operand width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per clock; NCH = M/CHUNK chunk cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  redundant pair present.
- in_ready  output  1  block can accept a pair.
- in_sum  input  M  XOR (sum) vector from the CSA stage.
- in_cout  input  M  carry vector, unshifted; weight 2 is applied internally.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_soma  output  M  low M bits of the result.
- out_carry  output  2  bits M+1:M of the result; range 0..2.
- busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: while rst is high at an edge, state goes to IDLE, the chunk index and internal carry clear to 0, and out_soma/out_carry clear to 0. in_ready=0 and out_valid=0 while rst is high. rst overrides every other event, including reset mid-RUN or mid-DONE; a partial result is discarded and never presented.
- in_ready = (state==IDLE) and not rst. out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE, in_valid=1 at edge k:
  - Capture s_reg=in_sum and c_reg={in_cout,1'b0} (M+1 bits).
  - Clear the chunk index and carry-in; go to RUN.
- RUN, one chunk per edge, index i=0..NCH-1, LSB chunk first:
  - {cy, r[i]} = s_reg[i] + c_reg[i] + cy, each slice CHUNK bits wide.
  - The result chunk is written into out_soma.
- At the NCH-th RUN edge, out_carry = c_reg[M] + cy (2-bit sum, no truncation); go to DONE.
- Latency: out_valid is high starting after edge k+NCH; this is 2 cycles for the defaults.
- DONE:
  - out_soma and out_carry are held stable; new in_valid is ignored (in_ready=0).
  - On out_valid & out_ready at an edge, go to IDLE. in_ready rises the cycle after.
- Throughput: one pair per NCH+2 cycles with out_ready tied high.
- Width rule: the full result is M+2 bits; nothing is truncated. The maximum is 3*(2^M-1).
- out_soma/out_carry are undefined-free: they retain the last result until the next write or rst.

Optional Feature:
- Macro: CSA_RES_ZERO_SKIP_EN.
- Defined: if in_cout==0 at acceptance, load out_soma=in_sum and out_carry=0 and go IDLE→DONE directly. out_valid is then high after edge k (1-cycle latency).
- Undefined: every pair takes the full NCH RUN cycles regardless of value.

Decomposition:
- Package csa_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Default width constants M_DEF=8, CHUNK_DEF=4.
  - Function returning NCH, plus a parameter-legality check (M % CHUNK == 0).
- Sub-module csa_chunk_add: combinational CHUNK-bit adder with cin and cout, instantiated once and shared across chunk cycles.
- FSM, registers and handshake stay in csa_resolver.

Test Plan:
- Defaults, out_ready=1, sum=0x0F, cout=0x01 -> out_soma=0x11, out_carry=0, out_valid 2 cycles after acceptance.
- sum=0x0A, cout=0x03 (carry crosses the chunk boundary) -> out_soma=0x10, out_carry=0.
- sum=0xFF, cout=0xFF -> 765: out_soma=0xFD, out_carry=2.
- Result 0x11 held with out_ready=0 for 5 cycles while in_valid toggles -> outputs stable, in_ready=0, no extra acceptance. out_ready=1 -> out_valid drops next cycle and in_ready rises.
- rst pulsed one cycle after acceptance of sum=0xFF, cout=0xFF -> out_valid never rises and outputs read 0. Next pair sum=0x01, cout=0x01 -> out_soma=0x03, out_carry=0.
- sum=0x5A, cout=0x00 -> out_soma=0x5A, out_carry=0. Latency is 1 cycle with CSA_RES_ZERO_SKIP_EN defined and 2 cycles without.
